// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and default sizing.
package fetch_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {address, word}; flush empties it and wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [2*WIDTH-1:0]         push_entry,
  output logic [2*WIDTH-1:0]         head_entry,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // The owner never pushes when full nor pops when empty, so no guards here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/issue FSM driving a one-cycle-latency ROM into a prefetch FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_address,
  output logic [WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_address,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_address,
  input  logic             instr_ready,
  output fetch_state_e     fsm_state
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_e       state, state_next;
  logic [WIDTH-1:0]   pc, pc_next;
  logic               pending, pending_next;
  logic [WIDTH-1:0]   pending_addr, pending_addr_next;
  logic [AW:0]        count;
  logic [AW+1:0]      occupancy;
  logic               issue;
  logic               capture;
  logic               pop;
  logic               flush;
  logic [2*WIDTH-1:0] head_entry;

  // Handshake: the head transfers on any edge where instr_valid && instr_ready
  // and no redirect is present; instr_valid never depends on instr_ready.
  assign occupancy = {1'b0, count} + {{(AW + 1){1'b0}}, pending};
  assign issue     = (state == FETCH) && !redirect_valid && (occupancy < (AW + 2)'(DEPTH));
  assign capture   = pending && !redirect_valid;
  assign flush     = (state == FETCH) && redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= '0;
      pending      <= 1'b0;
      pending_addr <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      pending      <= pending_next;
      pending_addr <= pending_addr_next;
    end
  end

  always_comb begin
    state_next        = state;
    pc_next           = pc;
    pending_next      = pending;
    pending_addr_next = pending_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = FETCH;
          pc_next      = start_address;
          pending_next = 1'b0;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_next      = redirect_address;
          pending_next = 1'b0;
        end else if (issue) begin
          pc_next           = pc + 1'b1;
          pending_next      = 1'b1;
          pending_addr_next = pc;
        end else begin
          pending_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (capture),
    .pop        (pop),
    .flush      (flush),
    .push_entry ({pending_addr, rom_data}),
    .head_entry (head_entry),
    .count      (count)
  );

  assign rom_address   = pc;
  assign instr_valid   = (count != '0);
  assign instr_address = head_entry[2*WIDTH-1:WIDTH];
  assign instr_data    = head_entry[WIDTH-1:0];
  assign fsm_state     = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle ROM model and an address scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] ROM_XOR = 32'hA5A5_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [31:0]  start_address;
  logic [31:0]  rom_address;
  logic [31:0]  rom_data = '0;
  logic         redirect_valid;
  logic [31:0]  redirect_address;
  logic         instr_valid;
  logic [31:0]  instr_data;
  logic [31:0]  instr_address;
  logic         instr_ready;
  fetch_state_e fsm_state;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ROM: registered read, one-cycle latency
  always_ff @(posedge clk) rom_data <= rom_address ^ ROM_XOR;

  fetch_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_address    (start_address),
    .rom_address      (rom_address),
    .rom_data         (rom_data),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_address    (instr_address),
    .instr_ready      (instr_ready),
    .fsm_state        (fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard check of the handshake the coming posedge performs, then advance one cycle.
  task automatic cycle();
    logic [31:0] e;
    if (instr_valid && instr_ready && !redirect_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious: got addr %h expected no delivery", instr_address);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliver_addr", instr_address, e);
        chk("deliver_data", instr_data, e ^ ROM_XOR);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic restart(input logic [31:0] addr, input logic ready);
    start_address = addr;
    instr_ready   = ready;
    start         = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_address = '0;
    redirect_valid = 1'b0; redirect_address = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_rom_addr", rom_address, 0);
    chk("rst_state", fsm_state, IDLE);
    reset_n = 1'b1;

    // redirect in IDLE is ignored
    redirect_valid = 1'b1; redirect_address = 32'h80;
    cycle();
    chk("idle_redirect_state", fsm_state, IDLE);
    chk("idle_redirect_pc", rom_address, 0);

    // start together with redirect: start wins; then streaming with no bubbles
    for (int i = 0; i < 12; i++) exp_q.push_back(i);
    instr_ready = 1'b1; start = 1'b1; start_address = 32'h0;
    cycle();
    start = 1'b0; redirect_valid = 1'b0;
    chk("start_state", fsm_state, FETCH);
    chk("start_pc", rom_address, 0);
    chk("lat_valid0", instr_valid, 0);
    cycle();
    chk("lat_valid1", instr_valid, 0);
    cycle();
    chk("lat_valid2", instr_valid, 1);
    for (int i = 0; i < 12; i++) begin
      chk("no_bubble", instr_valid, 1);
      cycle();
    end
    instr_ready = 1'b0;
    chk("stream_drained", exp_q.size(), 0);

    // backpressure: exactly DEPTH words buffered, then released without loss
    do_reset();
    restart(32'h0, 1'b0);
    repeat (10) cycle();
    chk("full_rom_addr", rom_address, 4);
    chk("full_head", instr_address, 0);
    chk("full_valid", instr_valid, 1);
    for (int i = 0; i < 10; i++) exp_q.push_back(i);
    instr_ready = 1'b1;
    drain(30);
    instr_ready = 1'b0;

    // redirect with 3 buffered and 1 pending
    do_reset();
    restart(32'h10, 1'b0);
    repeat (4) cycle();
    chk("pre_redir_head", instr_address, 32'h10);
    chk("pre_redir_pc", rom_address, 32'h14);
    redirect_valid = 1'b1; redirect_address = 32'h40; instr_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    chk("flush_valid", instr_valid, 0);
    chk("flush_pc", rom_address, 32'h40);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + i);
    cycle();
    chk("redir_lat", instr_valid, 0);
    drain(12);
    instr_ready = 1'b0;

    // PC wrap
    do_reset();
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    restart(32'hFFFF_FFFE, 1'b1);
    drain(12);
    instr_ready = 1'b0;

    // asynchronous reset mid-stream with words buffered
    repeat (4) cycle();
    chk("pre_async_valid", instr_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_pc", rom_address, 0);
    chk("async_state", fsm_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_reset_quiet", instr_valid, 0);
      cycle();
    end

    // redirect on the same edge as a pop with the FIFO full
    restart(32'h100, 1'b0);
    repeat (8) cycle();
    chk("full6_valid", instr_valid, 1);
    chk("full6_pc", rom_address, 32'h104);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_address = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    chk("flush_full_valid", instr_valid, 0);
    chk("flush_full_pc", rom_address, 32'h200);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + i);
    drain(12);
    instr_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets the address and instruction-word width.
REQ-002 Parameter DEPTH, default 4, sets the prefetch FIFO entries; must be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level; leaves IDLE and begins fetching at start_address.
REQ-006 start_address  input  WIDTH  first word address fetched after start.
REQ-007 rom_address  output  WIDTH  word address to the shared ROM port; driven directly from the PC register.
REQ-008 rom_data  input  WIDTH  ROM read data, registered by the ROM, one-cycle latency.
REQ-009 redirect_valid  input  1  branch/jump request, one-cycle pulse.
REQ-010 redirect_address  input  WIDTH  branch target word address.
REQ-011 instr_valid  output  1  FIFO head is valid.
REQ-012 instr_data  output  WIDTH  FIFO head instruction word (two packed 16-bit sub-instructions, passed through untouched).
REQ-013 instr_address  output  WIDTH  word address of the instruction on instr_data.
REQ-014 instr_ready  input  1  consumer accepts the head when high together with instr_valid.

Function
REQ-015 FSM states: IDLE and FETCH; IDLE goes to FETCH when start=1 (pc<=start_address); FETCH never returns to IDLE except by reset.
REQ-016 Issue condition at an edge: state=FETCH, redirect_valid=0, and (count + pending) < DEPTH; on issue pc<=pc+1, pending<=1, pending_addr<=pc.
REQ-017 Capture: at the edge after an issue, rom_data is pushed with pending_addr if no redirect at that edge; pending clears unless a new issue occurs.
REQ-018 Latency: an address on rom_address at issue edge E appears at the FIFO head at earliest after edge E+1 (instr_valid high in cycle after E+1).
REQ-019 Steady state, with instr_ready held at 1: one instruction delivered per cycle, no bubbles.
REQ-020 Pop occurs when instr_valid and instr_ready are both 1; push and pop at the same edge are both performed and count is unchanged.
REQ-021 Full: no issue while count+pending = DEPTH; no FIFO entry is ever overwritten.
REQ-022 Empty: instr_valid=0; instr_data and instr_address are don't-care.
REQ-023 Redirect: it has priority over issue, capture and pop; at that edge the FIFO is flushed, pending cleared, and pc<=redirect_address; fetching resumes the next edge.
REQ-024 A redirect in IDLE is ignored; start and redirect together in IDLE: start wins.
REQ-025 pc increments modulo 2^WIDTH; 2^WIDTH-1 wraps to 0 with no special handling.
REQ-026 count is log2(DEPTH)+1 bits; read/write pointers are log2(DEPTH) bits and wrap naturally.

Reset
REQ-027 Asserting reset_n low immediately forces state=IDLE, pc=0, pending=0, count=0, pointers=0, instr_valid=0, and rom_address=0.
REQ-028 Reset mid-fetch discards all in-flight and buffered words; nothing is delivered after reset until a new start.

Structure
REQ-029 The package fetch_pkg holds the state encoding (IDLE, FETCH) and the defaults for WIDTH and DEPTH.
REQ-030 A sub-module fetch_fifo (DEPTH x 2*WIDTH, push/pop/flush, count output) holds the prefetch buffer; the FSM, PC and issue logic stay in fetch_unit.

Verification
REQ-031 Model the ROM with one-cycle latency, data = address XOR 32'hA5A5_0000. start_address=0, instr_ready=1 -> addresses 0,1,2,3,... delivered on consecutive cycles; first instr_valid two cycles after start is sampled.
REQ-032 Hold instr_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered (0..3), rom_address holds at 4; release -> words 4,5,... follow with no loss or duplication.
REQ-033 Redirect to 0x40 while the FIFO holds 3 words and one word is pending -> all flushed; next delivered addresses are 0x40, 0x41; stale words never appear.
REQ-034 start_address=32'hFFFF_FFFE -> delivered addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-035 Assert reset_n low asynchronously (between edges) mid-stream -> instr_valid=0 and rom_address=0 immediately; no output until the next start.
REQ-036 Redirect on the same edge as a pop with the FIFO full -> FIFO empty afterwards, count=0, fetch resumes at the target.
